ul_write_axis: RTL and testbench



---
 rtl/ul_write_axis.sv | 151 +++++++++++++++
 tb/tb_ul_write_axis.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ul_write_axis.sv
// UL write -> N-way AXI-Stream demux: captures address + data, raises one-hot valid on the addressed port.
// Latency 1 cycle from completing handshake to valid; UL channels stay closed until the beat is taken.
// Optional macro UL_WRITE_AXIS_TIMEOUT_EN: drop a beat the selected port never accepts, count drops.
module ul_write_axis #(
    parameter int DATA_WIDTH   = 32,
    parameter int NBITS        = 4,
    parameter int N            = 1 << NBITS,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic                  s_ul_clk,
    input  logic                  s_ul_aresetn,
    input  logic [NBITS-1:0]      s_ul_awaddr,
    input  logic                  s_ul_awvalid,
    output logic                  s_ul_awready,
    input  logic [DATA_WIDTH-1:0] s_ul_wdata,
    input  logic                  s_ul_wvalid,
    output logic                  s_ul_wready,
    output logic [N-1:0]          axis_port_valid,
    input  logic [N-1:0]          axis_port_ready,
    output logic [DATA_WIDTH-1:0] axis_port_data,
    output logic [NBITS-1:0]      axis_port_addr,
    output logic                  axis_port_addr_valid
`ifdef UL_WRITE_AXIS_TIMEOUT_EN
    ,
    output logic [7:0]            axis_drop_cnt
`endif
);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t                state_q, state_d;
    logic                  aw_got_q, aw_got_d;
    logic                  w_got_q, w_got_d;
    logic [NBITS-1:0]      sel_q, sel_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [N-1:0]          valid_q, valid_d;

    logic aw_hs, w_hs, pair_done, sel_ready, timeout_hit;

    assign aw_hs     = s_ul_awvalid & s_ul_awready;
    assign w_hs      = s_ul_wvalid & s_ul_wready;
    assign pair_done = (aw_got_q | aw_hs) & (w_got_q | w_hs);
    assign sel_ready = axis_port_ready[sel_q];

`ifdef UL_WRITE_AXIS_TIMEOUT_EN
    // Drop on the edge where the counter would reach all-ones: valid is held 2^T-1 cycles.
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST = ~TIMEOUT_BITS'(1);

    logic [TIMEOUT_BITS-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]              drop_cnt_q, drop_cnt_d;

    assign timeout_hit = (state_q == ST_SEND) && !sel_ready && (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d   = to_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (state_q != ST_SEND) begin
            to_cnt_d = '0;
        end else if (!sel_ready) begin
            to_cnt_d = to_cnt_q + TIMEOUT_BITS'(1);
        end
        if (timeout_hit && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge s_ul_clk or negedge s_ul_aresetn) begin
        if (!s_ul_aresetn) begin
            to_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign axis_drop_cnt = drop_cnt_q;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge s_ul_clk or negedge s_ul_aresetn) begin
        if (!s_ul_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (pair_done) state_d = ST_SEND;
            ST_SEND: if (sel_ready || timeout_hit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ul_awready         = (state_q == ST_IDLE) & ~aw_got_q;
        s_ul_wready          = (state_q == ST_IDLE) & ~w_got_q;
        axis_port_addr_valid = (state_q == ST_SEND);
    end

    always_comb begin
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        sel_d    = sel_q;
        data_d   = data_q;
        valid_d  = valid_q;
        if (state_q == ST_IDLE) begin
            if (aw_hs) begin
                aw_got_d = 1'b1;
                sel_d    = s_ul_awaddr;
            end
            if (w_hs) begin
                w_got_d = 1'b1;
                data_d  = s_ul_wdata;
            end
            if (pair_done) begin
                aw_got_d       = 1'b0;
                w_got_d        = 1'b0;
                valid_d        = '0;
                valid_d[sel_d] = 1'b1;
            end
        end else if (sel_ready || timeout_hit) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge s_ul_clk or negedge s_ul_aresetn) begin
        if (!s_ul_aresetn) begin
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            sel_q    <= '0;
            data_q   <= '0;
            valid_q  <= '0;
        end else begin
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign axis_port_valid = valid_q;
    assign axis_port_data  = data_q;
    assign axis_port_addr  = sel_q;

endmodule

// File: tb/tb_ul_write_axis.sv
// Directed bench for ul_write_axis: inputs driven and outputs sampled on the falling edge.
module tb_ul_write_axis;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int NP = 1 << NB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [NP-1:0] pvalid;
    logic [NP-1:0] pready = '0;
    logic [DW-1:0] pdata;
    logic [NB-1:0] paddr;
    logic          paddr_vld;
`ifdef UL_WRITE_AXIS_TIMEOUT_EN
    logic [7:0]    drop_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ul_write_axis #(.DATA_WIDTH(DW), .NBITS(NB), .N(NP), .TIMEOUT_BITS(4)) dut (
        .s_ul_clk             (clk),
        .s_ul_aresetn         (rst_n),
        .s_ul_awaddr          (awaddr),
        .s_ul_awvalid         (awvalid),
        .s_ul_awready         (awready),
        .s_ul_wdata           (wdata),
        .s_ul_wvalid          (wvalid),
        .s_ul_wready          (wready),
        .axis_port_valid      (pvalid),
        .axis_port_ready      (pready),
        .axis_port_data       (pdata),
        .axis_port_addr       (paddr),
        .axis_port_addr_valid (paddr_vld)
`ifdef UL_WRITE_AXIS_TIMEOUT_EN
        ,
        .axis_drop_cnt        (drop_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call on a falling edge; returns on the falling edge after the handshake edge.
    task automatic ul_write(input logic [NB-1:0] a, input logic [DW-1:0] d);
        int waited = 0;
        while (!(awready && wready) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("wr_open_timeout", 64'(waited < 50), 64'd1);
        awaddr = a; awvalid = 1'b1; wdata = d; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(pvalid), 64'd0);
        check("rst_data", 64'(pdata), 64'd0);
        check("rst_addr", 64'(paddr), 64'd0);
        check("rst_addr_vld", 64'(paddr_vld), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_awready", 64'(awready), 64'd1);
        check("idle_wready", 64'(wready), 64'd1);

        // Same-cycle handshake
        pready = 16'h0008;
        ul_write(4'd3, 32'hDEADBEEF);
        check("sc_valid", 64'(pvalid), 64'h8);
        check("sc_data", 64'(pdata), 64'hDEADBEEF);
        check("sc_addr", 64'(paddr), 64'd3);
        check("sc_addr_vld", 64'(paddr_vld), 64'd1);
        check("sc_awready_low", 64'(awready), 64'd0);
        @(negedge clk);
        check("sc_valid_1cyc", 64'(pvalid), 64'd0);
        check("sc_awready_back", 64'(awready), 64'd1);
        check("sc_wready_back", 64'(wready), 64'd1);
        check("sc_data_hold", 64'(pdata), 64'hDEADBEEF);

        // Data before address
        pready = 16'h0020;
        wdata = 32'h12345678; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check("dba_wready_low", 64'(wready), 64'd0);
            check("dba_awready_high", 64'(awready), 64'd1);
            check("dba_no_valid", 64'(pvalid), 64'd0);
            if (i < 3) @(negedge clk);
        end
        awaddr = 4'd5; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("dba_valid", 64'(pvalid), 64'h20);
        check("dba_data", 64'(pdata), 64'h12345678);
        @(negedge clk);
        check("dba_valid_clear", 64'(pvalid), 64'd0);

        // Backpressure on port 7, port 2 ready toggling
        pready = '0;
        ul_write(4'd7, 32'hCAFE0007);
        for (int i = 0; i <= 10; i++) begin
            check("bp_valid", 64'(pvalid), 64'h80);
            check("bp_data", 64'(pdata), 64'hCAFE0007);
            check("bp_addr", 64'(paddr), 64'd7);
            check("bp_awready", 64'(awready), 64'd0);
            check("bp_wready", 64'(wready), 64'd0);
            pready[2] = ~pready[2];
            if (i == 10) pready[7] = 1'b1;
            @(negedge clk);
        end
        check("bp_valid_clear", 64'(pvalid), 64'd0);
        check("bp_awready_back", 64'(awready), 64'd1);

        // Back-to-back, all ready: one beat every 2 cycles
        pready = '1;
        for (int n = 0; n < 8; n++) begin
            if (n % 2 == 0) begin
                check("b2b_gap_valid", 64'(pvalid), 64'd0);
                check("b2b_awready", 64'(awready), 64'd1);
                awaddr = NB'(n / 2); wdata = DW'(n / 2 + 1);
                awvalid = 1'b1; wvalid = 1'b1;
            end else begin
                awvalid = 1'b0; wvalid = 1'b0;
                check("b2b_valid", 64'(pvalid), 64'(1) << (n / 2));
                check("b2b_data", 64'(pdata), 64'(n / 2 + 1));
            end
            @(negedge clk);
        end
        check("b2b_end_valid", 64'(pvalid), 64'd0);

        // Asynchronous reset mid-beat
        pready = '0;
        ul_write(4'd9, 32'hA5A5A5A5);
        check("ar_valid_pending", 64'(pvalid), 64'h200);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(pvalid), 64'd0);
        check("ar_data", 64'(pdata), 64'd0);
        check("ar_addr", 64'(paddr), 64'd0);
        check("ar_addr_vld", 64'(paddr_vld), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pready = 16'h0002;
        @(negedge clk);
        ul_write(4'd1, 32'h00000055);
        check("ar_post_valid", 64'(pvalid), 64'h2);
        check("ar_post_data", 64'(pdata), 64'h55);
        @(negedge clk);
        check("ar_post_clear", 64'(pvalid), 64'd0);

`ifdef UL_WRITE_AXIS_TIMEOUT_EN
        // Timeout drops with TIMEOUT_BITS=4
        pready = '0;
        for (int r = 0; r < 300; r++) begin
            int hi = 0;
            ul_write(4'd1, DW'(r));
            while (pvalid == 16'h0002 && hi < 40) begin
                hi++;
                @(negedge clk);
            end
            if (r == 0) begin
                check("to_valid_cycles", 64'(hi), 64'd15);
                check("to_drop_one", 64'(drop_cnt), 64'd1);
            end
        end
        check("to_drop_sat", 64'(drop_cnt), 64'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
